// File: rtl/fft_spectrum_sched_if.sv
// fft_spectrum_sched_if
//   Writer-side streaming bus into the spectrum scheduler.
//   The FFT-magnitude writer drives the master modport and the scheduler takes the slave modport.
//   Signals:
//     wr_valid  writer data valid
//     wr_data   magnitude sample
//     wr_last   final sample of a spectrum
//     wr_ready  scheduler accepts a write (backpressure)
`timescale 1ns/1ps
interface fft_spectrum_sched_if #(
   parameter int DW = 8
);
   logic          wr_valid;
   logic [DW-1:0] wr_data;
   logic          wr_last;
   logic          wr_ready;

   modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
   modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/fft_spectrum_sched.sv
// fft_spectrum_sched
//   Ping-pong scheduler for the FFT magnitude store that feeds the LCD spectrum display.
//   The writer fills the back bank while the display reads the front bank. The banks swap
//   only on frame_start once the back bank is full, so a displayed frame never mixes spectra.
//   Ports:
//     lcd_pclk, rst_n   pixel clock, asynchronous active-low reset
//     frame_start       one-cycle pulse at each displayed frame start
//     data_req          advance to the next spectrum point (saturates at N_POINTS-1)
//     fft_point_done    end-of-line pulse, rewinds the point index
//     fft_point_cnt     point index presented to the display
//     fft_data          registered front-bank magnitude at fft_point_cnt
//     disp_bank         bank currently shown
//     ovf_err           sticky, set when samples beyond N_POINTS were dropped
//     wr_if             writer bus (slave side)
//   Optional feature macro SCHED_FREEZE_EN: adds input freeze, which holds off the swap
//   while asserted.
`timescale 1ns/1ps
module fft_spectrum_sched #(
   parameter int N_POINTS = 128,
   parameter int DW       = 8,
   parameter int AW       = 7
) (
   input  logic                   lcd_pclk,
   input  logic                   rst_n,
   input  logic                   frame_start,
   input  logic                   data_req,
   input  logic                   fft_point_done,
`ifdef SCHED_FREEZE_EN
   input  logic                   freeze,
`endif
   output logic [7:0]             fft_point_cnt,
   output logic [DW-1:0]          fft_data,
   output logic                   disp_bank,
   output logic                   ovf_err,
   fft_spectrum_sched_if.slave    wr_if
);

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FILL = 2'd1,
      W_FULL = 2'd2
   } wstate_e;

   wstate_e       state_q, state_d;
   // One spare MSB lets the address reach N_POINTS, which marks the bank as overfilled.
   logic [AW:0]   addr_q, addr_d;
   logic          bank_q, bank_d;
   logic          ovf_q, ovf_d;
   logic          ready_q, ready_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [DW-1:0] rdata_q;
   logic          accept;
   logic          we;
   logic          hold;

   // Bank select is the MSB of the index: {bank, point}.
   logic [DW-1:0] mem [0:2*N_POINTS-1];

`ifdef SCHED_FREEZE_EN
   assign hold = freeze;
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      addr_d  = addr_q;
      bank_d  = bank_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;

      accept = wr_if.wr_valid && ready_q;
      we     = accept && !addr_q[AW];

      if (we) addr_d = addr_q + {{AW{1'b0}}, 1'b1};
      // Samples past the end of the bank are dropped, but the spectrum still ends on wr_last.
      if (accept && addr_q[AW]) ovf_d = 1'b1;

      unique case (state_q)
         W_IDLE: if (accept) state_d = wr_if.wr_last ? W_FULL : W_FILL;
         W_FILL: if (accept && wr_if.wr_last) state_d = W_FULL;
         W_FULL: begin
            // A frame_start that coincides with the wr_last write arrives while still
            // filling, so the swap waits for the following frame boundary.
            if (frame_start && !hold) begin
               state_d = W_IDLE;
               bank_d  = ~bank_q;
               addr_d  = '0;
            end
         end
         default: state_d = W_IDLE;
      endcase

      // Line end / frame start rewinds the index and beats data_req in the same cycle.
      if (frame_start || fft_point_done)                  cnt_d = '0;
      else if (data_req && cnt_q != 8'(N_POINTS - 1))     cnt_d = cnt_q + 8'd1;

      // Registered ready follows the next state, so it drops the cycle after the last
      // write and rises the cycle after the swap; it is low out of reset.
      ready_d = (state_d != W_FULL);
   end

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= W_IDLE;
         addr_q  <= '0;
         bank_q  <= 1'b0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         addr_q  <= addr_d;
         bank_q  <= bank_d;
         ovf_q   <= ovf_d;
         ready_q <= ready_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: the magnitude store has no reset; its contents are don't-care until the first
   // swap, and leaving it unreset keeps it mappable onto block RAM.
   always_ff @(posedge lcd_pclk) begin
      if (we) mem[{~bank_q, addr_q[AW-1:0]}] <= wr_if.wr_data;
   end

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= mem[{bank_q, cnt_q[AW-1:0]}];
   end

   assign fft_point_cnt  = cnt_q;
   assign fft_data       = rdata_q;
   assign disp_bank      = bank_q;
   assign ovf_err        = ovf_q;
   assign wr_if.wr_ready = ready_q;

endmodule

// File: tb/tb_fft_spectrum_sched.sv
`timescale 1ns/1ps
module tb_fft_spectrum_sched;
   localparam int N  = 128;
   localparam int DW = 8;

   logic          lcd_pclk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_start = 1'b0;
   logic          data_req = 1'b0;
   logic          fft_point_done = 1'b0;
`ifdef SCHED_FREEZE_EN
   logic          freeze = 1'b0;
`endif
   logic [7:0]    fft_point_cnt;
   logic [DW-1:0] fft_data;
   logic          disp_bank;
   logic          ovf_err;

   fft_spectrum_sched_if #(.DW(DW)) wr_if ();

   fft_spectrum_sched #(.N_POINTS(N), .DW(DW), .AW(7)) dut (
      .lcd_pclk       (lcd_pclk),
      .rst_n          (rst_n),
      .frame_start    (frame_start),
      .data_req       (data_req),
      .fft_point_done (fft_point_done),
`ifdef SCHED_FREEZE_EN
      .freeze         (freeze),
`endif
      .fft_point_cnt  (fft_point_cnt),
      .fft_data       (fft_data),
      .disp_bank      (disp_bank),
      .ovf_err        (ovf_err),
      .wr_if          (wr_if)
   );

   always #5 lcd_pclk = ~lcd_pclk;

   typedef enum {S_CNT, S_DATA, S_READY, S_BANK, S_OVF} sig_e;
   typedef struct {
      string       name;
      sig_e        sig;
      int unsigned exp;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  model_mem [2][N];
   logic        exp_bank = 1'b0;
   logic        exp_ovf  = 1'b0;
   exp_t        mon_e;
   logic [31:0] mon_act;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic exp_push(input string name, input sig_e sig, input int unsigned val);
      exp_t e;
      e.name = name;
      e.sig  = sig;
      e.exp  = val;
      sb.push_back(e);
   endtask

   // Monitor: compares every queued expectation against the settled outputs.
   always @(negedge lcd_pclk) begin
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         case (mon_e.sig)
            S_CNT:   mon_act = {24'd0, fft_point_cnt};
            S_DATA:  mon_act = {24'd0, fft_data};
            S_READY: mon_act = {31'd0, wr_if.wr_ready};
            S_BANK:  mon_act = {31'd0, disp_bank};
            default: mon_act = {31'd0, ovf_err};
         endcase
         check(mon_e.name, mon_act, mon_e.exp);
      end
   end

   task automatic tick();
      @(posedge lcd_pclk);
      #1;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (wr_if.wr_ready !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      check("wr_ready_wait", {31'd0, wr_if.wr_ready}, 32'd1);
   endtask

   // Streams n samples; value is i or a constant; frame_start pulses on sample fs_at.
   task automatic wr_burst(input int n, input bit const_mode, input logic [7:0] val, input int fs_at);
      wait_ready();
      for (int i = 0; i < n; i++) begin
         wr_if.wr_valid = 1'b1;
         wr_if.wr_data  = const_mode ? val : 8'(i);
         wr_if.wr_last  = (i == n - 1);
         frame_start    = (i == fs_at);
         if (i < N) model_mem[exp_bank ^ 1'b1][i] = wr_if.wr_data;
         else       exp_ovf = 1'b1;
         tick();
         if (i == fs_at && i != n - 1) exp_push("no_swap_while_filling", S_BANK, exp_bank);
      end
      wr_if.wr_valid = 1'b0;
      wr_if.wr_last  = 1'b0;
      frame_start    = 1'b0;
      exp_push("ready_low_when_full", S_READY, 0);
      exp_push("bank_held_after_fill", S_BANK, exp_bank);
      exp_push("ovf_err", S_OVF, exp_ovf);
   endtask

   task automatic do_swap();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      exp_bank    = exp_bank ^ 1'b1;
      exp_push("bank_after_swap", S_BANK, exp_bank);
      exp_push("ready_after_swap", S_READY, 1);
      exp_push("cnt_after_swap", S_CNT, 0);
   endtask

   // Reads every point of the front bank; fft_data lags the index by one cycle.
   task automatic scan(input string tag);
      fft_point_done = 1'b1;
      tick();
      fft_point_done = 1'b0;
      exp_push({tag, "_cnt0"}, S_CNT, 0);
      data_req = 1'b1;
      for (int k = 1; k < N; k++) begin
         tick();
         exp_push($sformatf("%s[%0d]", tag, k - 1), S_DATA, model_mem[exp_bank][k - 1]);
      end
      data_req = 1'b0;
      tick();
      exp_push($sformatf("%s[%0d]", tag, N - 1), S_DATA, model_mem[exp_bank][N - 1]);
      exp_push({tag, "_cnt_end"}, S_CNT, N - 1);
   endtask

   initial begin
      int w;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_data  = '0;
      wr_if.wr_last  = 1'b0;

      // Reset values.
      #2;
      exp_push("rst_cnt", S_CNT, 0);
      exp_push("rst_data", S_DATA, 0);
      exp_push("rst_ready", S_READY, 0);
      exp_push("rst_bank", S_BANK, 0);
      exp_push("rst_ovf", S_OVF, 0);
      #20 rst_n = 1'b1;
      tick();
      tick();

      // Full spectrum 0..127; writes while full must be ignored.
      wr_burst(N, 1'b0, 8'h00, -1);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 8'hEE;
      repeat (3) begin
         tick();
         exp_push("ready_low_backpressure", S_READY, 0);
      end
      wr_if.wr_valid = 1'b0;
      do_swap();
      exp_push("t1_bank_is_1", S_BANK, 1);
      data_req = 1'b1;
      repeat (5) tick();
      data_req = 1'b0;
      exp_push("cnt_after_5_req", S_CNT, 5);
      tick();
      exp_push("data_at_point5", S_DATA, 5);
      scan("t1_bank");

      // Index saturation and rewind priority.
      data_req = 1'b1;
      repeat (130) tick();
      data_req = 1'b0;
      exp_push("cnt_saturate", S_CNT, 127);
      fft_point_done = 1'b1;
      tick();
      fft_point_done = 1'b0;
      exp_push("cnt_line_end", S_CNT, 0);
      data_req = 1'b1;
      repeat (3) tick();
      exp_push("cnt_after_3_req", S_CNT, 3);
      fft_point_done = 1'b1;
      tick();
      fft_point_done = 1'b0;
      data_req       = 1'b0;
      exp_push("cnt_done_beats_req", S_CNT, 0);

      // Overflow: 130 samples, frame_start during the fill is ignored.
      wr_burst(130, 1'b0, 8'h00, 50);
      exp_push("ovf_set", S_OVF, 1);
      do_swap();
      exp_push("t3_bank_is_0", S_BANK, 0);
      scan("t3_ovf");
      exp_push("ovf_sticky", S_OVF, 1);

      // wr_last coincident with frame_start: swap deferred to the next frame.
      wr_burst(N, 1'b1, 8'h11, N - 1);
      tick();
      exp_push("t4_no_swap_same_cycle", S_BANK, 0);
      do_swap();
      exp_push("t4_swap_next_frame", S_BANK, 1);
      wr_burst(N, 1'b1, 8'h11, -1);
      do_swap();

      // Short spectrum over stale 0x11 content.
      wr_burst(64, 1'b1, 8'hAA, -1);
      do_swap();
      exp_push("t5_bank_is_1", S_BANK, 1);
      scan("t5_partial");

`ifdef SCHED_FREEZE_EN
      wr_burst(N, 1'b1, 8'h55, -1);
      freeze = 1'b1;
      repeat (3) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         tick();
         exp_push("freeze_bank_hold", S_BANK, exp_bank);
         exp_push("freeze_ready_low", S_READY, 0);
      end
      freeze = 1'b0;
      tick();
      do_swap();
      scan("freeze_bank");
`endif

      w = 0;
      while (sb.size() > 0 && w < 10) begin
         tick();
         w++;
      end
      @(negedge lcd_pclk);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
